// File: rtl/vga_pattern_gen.sv
// Test-pattern colour stage behind a 640x480 VGA sync generator; recovers x/y from video_on/vsync.
// Latency: rgb is registered, 1 clk after video_on, lining up with the generator's registered syncs.
// Backpressure: none; free-running pixel stream that follows the sync inputs every clock.
module vga_pattern_gen #(
    parameter int BOX  = 32,
    parameter int STEP = 4,
    parameter int HACT = 640,
    parameter int VACT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [1:0]  mode,
    input  logic [11:0] color,
    output logic [11:0] rgb,
    output logic [7:0]  frame_cnt
);

    localparam logic [9:0]  X_LIM  = 10'(HACT - BOX);
    localparam logic [9:0]  Y_LIM  = 10'(VACT - BOX);
    localparam logic [9:0]  STEP_W = 10'(STEP);
    localparam logic [10:0] BOX_W  = 11'(BOX);
    localparam logic [9:0]  C_MAX  = 10'h3FF;
    localparam int          BAR    = HACT / 8;

    logic        video_on_d;
    logic        vsync_d;
    logic        von_rise;
    logic        von_fall;
    logic        vs_rise;

    logic [9:0]  x_reg;
    logic        phase;
    logic [9:0]  y_reg;
    logic [9:0]  cur_x;
    logic        cur_phase;

    logic [1:0]  mode_q;
    logic [11:0] color_q;
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic        dir_x;     // 0 = moving right, 1 = moving left
    logic        dir_y;     // 0 = moving down, 1 = moving up

    logic [2:0]  bar;
    logic        in_box;
    logic [11:0] pattern;

    // One box axis step per frame: returns {direction, position}; bounces off 0 and lim.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic back,
                                           input logic [9:0] lim);
        logic [10:0] fwd;
        logic [10:0] res;
        fwd = {1'b0, pos} + {1'b0, STEP_W};
        if (!back) begin
            if (fwd >= {1'b0, lim}) res = {1'b1, lim};
            else                    res = {1'b0, fwd[9:0]};
        end else begin
            if (pos <= STEP_W) res = {1'b0, 10'd0};
            else               res = {1'b1, pos - STEP_W};
        end
        return res;
    endfunction

    // Edge detection on the sync inputs; the rising edge of video_on is pixel 0 of a line.
    always_comb begin
        von_rise  = video_on & ~video_on_d;
        von_fall  = ~video_on & video_on_d;
        vs_rise   = vsync & ~vsync_d;
        cur_x     = von_rise ? 10'd0 : x_reg;
        cur_phase = von_rise ? 1'b0 : phase;
    end

    // Delayed copies of video_on and vsync for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_on_d <= 1'b0;
            vsync_d    <= 1'b0;
        end else begin
            video_on_d <= video_on;
            vsync_d    <= vsync;
        end
    end

    // Horizontal position: two clocks per pixel, saturating so a long run cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_reg <= 10'd0;
            phase <= 1'b0;
        end else if (video_on) begin
            phase <= ~cur_phase;
            if (cur_phase && cur_x != C_MAX) x_reg <= cur_x + 10'd1;
            else                             x_reg <= cur_x;
        end
    end

    // Vertical position: one line per active run, cleared at frame start (frame start wins).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_reg <= 10'd0;
        end else if (vs_rise) begin
            y_reg <= 10'd0;
        end else if (von_fall && y_reg != C_MAX) begin
            y_reg <= y_reg + 10'd1;
        end
    end

    // Per-frame state: counter, latched pattern controls and box motion, so nothing tears mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'd0;
            mode_q    <= 2'd0;
            color_q   <= 12'h000;
            box_x     <= 10'd0;
            box_y     <= 10'd0;
            dir_x     <= 1'b0;
            dir_y     <= 1'b0;
        end else if (vs_rise) begin
            frame_cnt      <= frame_cnt + 8'd1;
            mode_q         <= mode;
            color_q        <= color;
            {dir_x, box_x} <= bounce(box_x, dir_x, X_LIM);
            {dir_y, box_y} <= bounce(box_y, dir_y, Y_LIM);
        end
    end

    // Pattern colour for the current pixel; bars use threshold compares instead of a divide.
    always_comb begin
        bar = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if ({1'b0, cur_x} < 11'((i + 1) * BAR)) bar = 3'(i);
        end
        in_box = ({1'b0, cur_x} >= {1'b0, box_x}) &&
                 ({1'b0, cur_x} <  ({1'b0, box_x} + BOX_W)) &&
                 ({1'b0, y_reg} >= {1'b0, box_y}) &&
                 ({1'b0, y_reg} <  ({1'b0, box_y} + BOX_W));
        pattern = 12'h000;
        case (mode_q)
            2'd0: begin
                case (bar)
                    3'd0:    pattern = 12'hFFF;
                    3'd1:    pattern = 12'hFF0;
                    3'd2:    pattern = 12'h0FF;
                    3'd3:    pattern = 12'h0F0;
                    3'd4:    pattern = 12'hF0F;
                    3'd5:    pattern = 12'hF00;
                    3'd6:    pattern = 12'h00F;
                    default: pattern = 12'h000;
                endcase
            end
            2'd1:    pattern = (cur_x[5] ^ y_reg[5]) ? 12'hFFF : 12'h000;
            2'd2:    pattern = in_box ? 12'hFFF : 12'h008;
            default: pattern = color_q;
        endcase
    end

    // Output register: blanked whenever video_on was low, matching the generator's sync delay.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rgb <= 12'h000;
        else          rgb <= video_on ? pattern : 12'h000;
    end

    // The generator never asserts hsync inside the active region.
    hsync_blank_only: assert property (@(posedge clk) disable iff (!reset_n) !(hsync && video_on));

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: reduced-size raster driven by a sync-generator model.
// Latency: expected rgb/frame_cnt are the model's result for the inputs of the previous clock.
// Backpressure: none; stimulus is a free-running raster plus short vsync-only frames.
module tb_vga_pattern_gen;

    localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VA = 40, VFP = 2, VSW = 2, VBP = 4;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = 2 * HT * VT;
    localparam int BOX_P = 8, STEP_P = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_on, hsync, vsync;
    logic [1:0]  mode;
    logic [11:0] color;
    logic [11:0] rgb;
    logic [7:0]  frame_cnt;

    vga_pattern_gen #(.BOX(BOX_P), .STEP(STEP_P), .HACT(HA), .VACT(VA)) dut (
        .clk(clk), .reset_n(reset_n), .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .mode(mode), .color(color), .rgb(rgb), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    // Reference model state (frame-level view of the block)
    int          m_fc, m_mode, m_bf, m_lines, m_run;
    logic [11:0] m_color;
    logic        m_von_d, m_vs_d;
    logic [11:0] exp_rgb;
    logic [7:0]  exp_fc;

    // Stimulus controls applied at the next drive point
    logic [1:0]  nmode;
    logic [11:0] ncolor;
    bit          rel_pending = 0;

    // Sync generator state
    int g_cc, g_vc;
    logic g_hs_r, g_vs_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    // Triangle-wave position of the box after n frames: reflects between 0 and lim.
    function automatic int bounce_pos(int n, int lim);
        int p;
        p = (n * STEP_P) % (2 * lim);
        return (p > lim) ? 2 * lim - p : p;
    endfunction

    function automatic logic [11:0] exp_pixel(int x, int y);
        int b, bx, by;
        case (m_mode)
            0: begin
                b = x / (HA / 8);
                if (b > 7) b = 7;
                case (b)
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
            2: begin
                bx = bounce_pos(m_bf, HA - BOX_P);
                by = bounce_pos(m_bf, VA - BOX_P);
                return (x >= bx && x < bx + BOX_P && y >= by && y < by + BOX_P) ? 12'hFFF : 12'h008;
            end
            default: return m_color;
        endcase
    endfunction

    task automatic model_reset();
        m_fc = 0; m_mode = 0; m_color = 12'h000; m_bf = 0; m_lines = 0; m_run = 0;
        m_von_d = 1'b0; m_vs_d = 1'b0;
        exp_rgb = 12'h000; exp_fc = 8'd0;
    endtask

    // Model for one clock with the given inputs; result is what the outputs show after the edge.
    task automatic model_step(input logic von, input logic vs);
        int x;
        if (von && !m_von_d) m_run = 0;
        x = m_run / 2;
        if (x > 1023) x = 1023;
        exp_rgb = von ? exp_pixel(x, m_lines) : 12'h000;
        if (von) m_run++;
        if (vs && !m_vs_d) begin
            m_fc = (m_fc + 1) % 256;
            m_mode = int'(mode);
            m_color = color;
            m_bf++;
            m_lines = 0;
        end else if (!von && m_von_d && m_lines < 1023) begin
            m_lines++;
        end
        exp_fc = 8'(m_fc);
        m_von_d = von;
        m_vs_d = vs;
    endtask

    // One clock: check outputs from the last edge, then drive the next inputs.
    task automatic cycle(input logic von, input logic hs, input logic vs);
        @(negedge clk);
        chk("rgb", 32'(rgb), 32'(exp_rgb));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        if (rel_pending) begin
            reset_n = 1'b1;
            rel_pending = 0;
        end
        mode = nmode;
        color = ncolor;
        video_on = von;
        hsync = hs;
        vsync = vs;
        if (!reset_n) model_reset();
        else          model_step(von, vs);
    endtask

    task automatic gen_restart();
        g_cc = 0; g_vc = 0; g_hs_r = 1'b0; g_vs_r = 1'b0;
    endtask

    // Sync generator: combinational video_on, syncs registered one clock later.
    task automatic gen_next(output logic von, output logic hs, output logic vs);
        int px;
        px = g_cc / 2;
        von = (px < HA) && (g_vc < VA);
        hs = g_hs_r;
        vs = g_vs_r;
        g_hs_r = (px >= HA + HFP) && (px < HA + HFP + HSW);
        g_vs_r = (g_vc >= VA + VFP) && (g_vc < VA + VFP + VSW);
        g_cc++;
        if (g_cc == 2 * HT) begin
            g_cc = 0;
            g_vc = (g_vc + 1) % VT;
        end
    endtask

    task automatic run(input int n);
        logic a, b, c;
        repeat (n) begin
            gen_next(a, b, c);
            cycle(a, b, c);
        end
    endtask

    // Frames with no active lines: just a vsync pulse, to advance frame state quickly.
    task automatic quick_frames(input int n);
        repeat (n) begin
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic hit_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        video_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
        nmode = 2'd0; ncolor = 12'h000;
        mode = 2'd0; color = 12'h000;
        model_reset();
        gen_restart();
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        rel_pending = 1;

        // Colour bars for two frames, then a mid-frame switch to checkerboard
        run(2 * FRAME);
        nmode = 2'd1;
        run(FRAME + 1000);

        // Bouncing box after a random number of fast frames, twice
        nmode = 2'd2;
        quick_frames($urandom_range(3, 40));
        gen_restart();
        run(FRAME);
        quick_frames($urandom_range(3, 40));
        gen_restart();
        run(FRAME / 2);

        // Solid colour, changed mid-frame; the new colour waits for the next frame
        nmode = 2'd3;
        ncolor = 12'(($urandom_range(0, 4095)));
        quick_frames(1);
        gen_restart();
        run(FRAME / 2);
        ncolor = 12'(($urandom_range(0, 4095)));
        run(FRAME);

        // Reset in the middle of an active line, released five clocks later
        nmode = 2'(($urandom_range(0, 3)));
        ncolor = 12'(($urandom_range(0, 4095)));
        gen_restart();
        run(5 * 2 * HT + $urandom_range(20, 100));
        hit_reset();
        run(5);
        rel_pending = 1;
        run(FRAME);

        // Counter wrap and long-run box position
        nmode = 2'd2;
        quick_frames(300);
        gen_restart();
        run(FRAME / 2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
